// File: rtl/imem_arb.sv
// Instruction-memory arbiter: a fetch port shares one memory port with a debug read port.
// Debug reads preempt fetch; a fetch response that lands during the debug issue is buffered and replayed.
module imem_arb #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int FETCH_MIN = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic [DATA_W-1:0] f_rdata,
    output logic [1:0]        f_bad,
    output logic              f_busy,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [1:0]        d_bad,
    output logic              m_req,
    output logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_bad,
    input  logic              m_busy
);

    typedef enum logic [1:0] {FETCH, DISSUE, DWAIT, REPLAY} state_e;

    localparam logic [3:0] WIN_MIN = 4'(FETCH_MIN);

    state_e              state_q, state_d;
    logic                out_q, out_d;
    logic                own_dbg_q, own_dbg_d;
    logic                buf_vld_q, buf_vld_d;
    logic [DATA_W-1:0]   buf_data_q, buf_data_d;
    logic [1:0]          buf_bad_q, buf_bad_d;
    logic [3:0]          win_q, win_d;
    logic                resp;
    logic                capture;

    assign resp    = out_q && !m_busy;
    assign capture = (state_q == DISSUE) && resp && !own_dbg_q;

    always_comb begin
        state_d    = state_q;
        buf_vld_d  = buf_vld_q;
        buf_data_d = buf_data_q;
        buf_bad_d  = buf_bad_q;
        win_d      = win_q;
        m_req      = 1'b0;
        m_addr     = f_addr;
        f_busy     = 1'b1;
        f_rdata    = '0;
        f_bad      = 2'b00;
        d_ack      = 1'b0;
        d_rdata    = '0;
        d_bad      = 2'b00;
        unique case (state_q)
            FETCH: begin
                m_req   = f_req;
                f_busy  = m_busy;
                f_rdata = m_rdata;
                f_bad   = m_bad;
                if (win_q != 4'hF) win_d = win_q + 4'd1;
                if (d_req && !m_busy && (win_q >= WIN_MIN)) state_d = DISSUE;
            end
            DISSUE: begin
                // m_req tracks d_req so a withdrawn debug read never reaches memory
                m_req  = d_req;
                m_addr = d_addr;
                if (capture) begin
                    buf_vld_d  = 1'b1;
                    buf_data_d = m_rdata;
                    buf_bad_d  = m_bad;
                end
                if (!d_req) begin
                    state_d = (buf_vld_q || capture) ? REPLAY : FETCH;
                end else if (!m_busy) begin
                    state_d = DWAIT;
                end
            end
            DWAIT: begin
                m_addr = d_addr;
                if (!m_busy) begin
                    d_ack   = 1'b1;
                    d_rdata = m_rdata;
                    d_bad   = m_bad;
                    if (buf_vld_q) begin
                        state_d = REPLAY;
                    end else begin
                        state_d = FETCH;
                        win_d   = 4'd0;
                    end
                end
            end
            REPLAY: begin
                m_req   = f_req;
                f_busy  = m_busy;
                f_rdata = buf_data_q;
                f_bad   = buf_bad_q;
                if (!m_busy) begin
                    buf_vld_d = 1'b0;
                    state_d   = FETCH;
                    win_d     = 4'd0;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        out_d     = out_q;
        own_dbg_d = own_dbg_q;
        if (m_req && !m_busy) begin
            out_d     = 1'b1;
            own_dbg_d = (state_q == DISSUE);
        end else if (resp) begin
            out_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH;
            out_q      <= 1'b0;
            own_dbg_q  <= 1'b0;
            buf_vld_q  <= 1'b0;
            buf_data_q <= '0;
            buf_bad_q  <= 2'b00;
            win_q      <= 4'hF;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            own_dbg_q  <= own_dbg_d;
            buf_vld_q  <= buf_vld_d;
            buf_data_q <= buf_data_d;
            buf_bad_q  <= buf_bad_d;
            win_q      <= win_d;
        end
    end

endmodule

// File: tb/tb_imem_arb.sv
// Bench for imem_arb: vector table, directed corner sequences, and a randomized run
// checked by transaction-level fetch/debug/memory models.
module tb_imem_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        f_req = 1'b0;
    logic [31:0] f_addr = '0;
    logic [31:0] f_rdata;
    logic [1:0]  f_bad;
    logic        f_busy;
    logic        d_req = 1'b0;
    logic [31:0] d_addr = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic [1:0]  d_bad;
    logic        m_req;
    logic [31:0] m_addr;
    logic [31:0] m_rdata = '0;
    logic [1:0]  m_bad = 2'b00;
    logic        m_busy = 1'b0;

    int checks = 0;
    int errors = 0;

    imem_arb #(.ADDR_W(32), .DATA_W(32), .FETCH_MIN(2)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_bad(f_bad), .f_busy(f_busy),
        .d_req(d_req), .d_addr(d_addr), .d_ack(d_ack), .d_rdata(d_rdata), .d_bad(d_bad),
        .m_req(m_req), .m_addr(m_addr), .m_rdata(m_rdata), .m_bad(m_bad), .m_busy(m_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mdat(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [1:0] mbad(input logic [31:0] a);
        return a[3:2] ^ a[5:4];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=response", nm);
    endtask

    // drive at posedge+1, return at posedge+6 for sampling
    task automatic cyc(input logic fr, input logic [31:0] fa, input logic dr, input logic [31:0] da,
                       input logic mb, input logic [31:0] md, input logic [1:0] mbd);
        @(posedge clk);
        #1;
        f_req = fr; f_addr = fa; d_req = dr; d_addr = da;
        m_busy = mb; m_rdata = md; m_bad = mbd;
        #5;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        f_req = 1'b0; d_req = 1'b0; m_busy = 1'b0; m_rdata = '0; m_bad = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic        fr;
        logic [31:0] fa;
        logic        mb;
        logic [31:0] md;
        logic [1:0]  mbd;
        logic        e_mreq;
        logic [31:0] e_maddr;
        logic        e_fbusy;
        logic [31:0] e_frd;
        logic [1:0]  e_fbad;
    } vec_t;

    vec_t vt[4];

    // random-phase models
    logic        mem_pend, mem_dbg_unused;
    logic [31:0] mem_a;
    logic        fo;
    logic [31:0] foa;
    logic        dq;
    logic [31:0] dqa;
    int          dwait, nda, nfr;

    task automatic rand_cycle(input bit allow_new);
        logic        fr, mb, resp, acc;
        logic [31:0] fa, md;
        logic [1:0]  mbd;
        fr = allow_new ? 1'($urandom_range(0, 1)) : 1'b0;
        fa = $urandom() & 32'hFFFF_FFFC;
        if (allow_new && !dq && $urandom_range(0, 5) == 0) begin
            dq    = 1'b1;
            dqa   = ($urandom() & 32'h0000_FFFC) | 32'h8000_0000;
            dwait = 0;
        end
        mb = ($urandom_range(0, 2) == 0);
        if (mem_pend && !mb) begin
            md  = mdat(mem_a);
            mbd = mbad(mem_a);
        end else begin
            md  = $urandom();
            mbd = 2'($urandom_range(0, 3));
        end
        cyc(fr, fa, dq, dqa, mb, md, mbd);

        if (!f_busy) begin
            if (fo) begin
                chk("rand_f_rdata", f_rdata, mdat(foa));
                chk("rand_f_bad", f_bad, mbad(foa));
                nfr++;
            end
            fo  = fr;
            foa = fa;
        end

        if (d_ack) begin
            chk("rand_d_ack_req", dq, 1'b1);
            chk("rand_d_rdata", d_rdata, mdat(dqa));
            chk("rand_d_bad", d_bad, mbad(dqa));
            dq = 1'b0;
            nda++;
        end else begin
            chk("rand_d_idle_zero", {d_rdata, d_bad}, 34'h0);
            if (dq) begin
                dwait++;
                if (dwait > 300) begin
                    fail("rand_d_timeout");
                    dq = 1'b0;
                end
            end
        end

        resp = mem_pend && !mb;
        acc  = m_req && !mb;
        if (acc) begin
            mem_pend = 1'b1;
            mem_a    = m_addr;
        end else if (resp) begin
            mem_pend = 1'b0;
        end
    endtask

    initial begin : main
        int gap;
        vt[0] = '{1'b1, 32'h0000_0010, 1'b0, 32'hAAAA_0001, 2'b00, 1'b1, 32'h0000_0010, 1'b0, 32'hAAAA_0001, 2'b00};
        vt[1] = '{1'b0, 32'h0000_0020, 1'b1, 32'h1234_5678, 2'b11, 1'b0, 32'h0000_0020, 1'b1, 32'h1234_5678, 2'b11};
        vt[2] = '{1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0F0F_F0F0, 2'b01, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0F0F_F0F0, 2'b01};
        vt[3] = '{1'b0, 32'h8000_0000, 1'b0, 32'hCAFE_BABE, 2'b10, 1'b0, 32'h8000_0000, 1'b0, 32'hCAFE_BABE, 2'b10};

        // reset state: FETCH pass-through, no debug activity
        #2;
        f_req = 1'b1; m_busy = 1'b1;
        #1;
        chk("rst_m_req_follows", m_req, 1'b1);
        chk("rst_f_busy_follows", f_busy, 1'b1);
        chk("rst_d_ack", d_ack, 1'b0);
        do_reset();

        foreach (vt[i]) begin
            cyc(vt[i].fr, vt[i].fa, 1'b0, 32'h0, vt[i].mb, vt[i].md, vt[i].mbd);
            chk($sformatf("vec%0d_m_req", i), m_req, vt[i].e_mreq);
            chk($sformatf("vec%0d_m_addr", i), m_addr, vt[i].e_maddr);
            chk($sformatf("vec%0d_f_busy", i), f_busy, vt[i].e_fbusy);
            chk($sformatf("vec%0d_f_rdata", i), f_rdata, vt[i].e_frd);
            chk($sformatf("vec%0d_f_bad", i), f_bad, vt[i].e_fbad);
            chk($sformatf("vec%0d_d_ack", i), d_ack, 1'b0);
        end

        // plain fetch stream
        do_reset();
        cyc(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h1111_1111, 2'b00);
        chk("fs_m_addr0", m_addr, 32'h0);
        chk("fs_d_ack0", d_ack, 1'b0);
        cyc(1'b1, 32'h4, 1'b0, 32'h0, 1'b0, mdat(32'h0), mbad(32'h0));
        chk("fs_m_addr4", m_addr, 32'h4);
        chk("fs_f_rdata0", f_rdata, mdat(32'h0));
        cyc(1'b1, 32'h8, 1'b0, 32'h0, 1'b0, mdat(32'h4), mbad(32'h4));
        chk("fs_m_addr8", m_addr, 32'h8);
        chk("fs_f_rdata4", f_rdata, mdat(32'h4));
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, mdat(32'h8), mbad(32'h8));
        chk("fs_f_rdata8", f_rdata, mdat(32'h8));
        chk("fs_d_ack_end", d_ack, 1'b0);

        // preemption with a fetch in flight: buffered then replayed
        do_reset();
        cyc(1'b1, 32'h100, 1'b1, 32'h8000, 1'b0, 32'h0, 2'b00);
        chk("pre_m_addr_fetch", m_addr, 32'h100);
        chk("pre_f_busy", f_busy, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 32'h8000, 1'b0, mdat(32'h100), 2'b10);
        chk("dis_m_req", m_req, 1'b1);
        chk("dis_m_addr", m_addr, 32'h8000);
        chk("dis_f_busy", f_busy, 1'b1);
        chk("dis_d_ack", d_ack, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 32'h8000, 1'b0, mdat(32'h8000), 2'b01);
        chk("dw_d_ack", d_ack, 1'b1);
        chk("dw_d_rdata", d_rdata, mdat(32'h8000));
        chk("dw_d_bad", d_bad, 2'b01);
        chk("dw_f_busy", f_busy, 1'b1);
        chk("dw_m_req", m_req, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF, 2'b11);
        chk("rp_f_busy", f_busy, 1'b0);
        chk("rp_f_rdata", f_rdata, mdat(32'h100));
        chk("rp_f_bad", f_bad, 2'b10);
        chk("rp_d_ack", d_ack, 1'b0);
        chk("rp_d_rdata_zero", d_rdata, 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h7777_0000, 2'b00);
        chk("rp_back_fetch", f_rdata, 32'h7777_0000);

        // memory stall during DWAIT, then FETCH_MIN spacing with d_req held
        do_reset();
        cyc(1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 32'h0, 2'b00);
        chk("st_pre_f_busy", f_busy, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 32'h0, 2'b00);
        chk("st_dis_m_addr", m_addr, 32'h40);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, $urandom(), 2'b11);
            chk($sformatf("st_busy%0d_d_ack", k), d_ack, 1'b0);
            chk($sformatf("st_busy%0d_f_busy", k), f_busy, 1'b1);
        end
        cyc(1'b0, 32'h0, 1'b1, 32'h40, 1'b0, mdat(32'h40), mbad(32'h40));
        chk("st_d_ack", d_ack, 1'b1);
        chk("st_d_rdata", d_rdata, mdat(32'h40));
        gap = 0;
        for (int n = 1; n <= 20; n++) begin
            cyc(1'b0, 32'h0, 1'b1, 32'h40, 1'b0, mdat(32'h40), mbad(32'h40));
            if (d_ack) begin
                gap = n;
                break;
            end
        end
        chk("win_gap", gap, 5);

        // reset in DWAIT with a buffered fetch
        do_reset();
        cyc(1'b1, 32'h200, 1'b1, 32'h9000, 1'b0, 32'h0, 2'b00);
        cyc(1'b0, 32'h0, 1'b1, 32'h9000, 1'b0, mdat(32'h200), 2'b10);
        cyc(1'b0, 32'h0, 1'b1, 32'h9000, 1'b1, 32'h0, 2'b00);
        chk("rw_in_dwait_d_ack", d_ack, 1'b0);
        #1;
        rst = 1'b1;
        f_req = 1'b1; m_busy = 1'b0;
        #1;
        chk("rw_async_f_busy", f_busy, 1'b0);
        chk("rw_async_m_req", m_req, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        f_req = 1'b0; d_req = 1'b0; m_busy = 1'b0; m_rdata = 32'h1234_5678; m_bad = 2'b00;
        #5;
        chk("rw_d_ack", d_ack, 1'b0);
        chk("rw_f_busy", f_busy, 1'b0);
        chk("rw_f_rdata_passthru", f_rdata, 32'h1234_5678);

        // randomized run against transaction models
        do_reset();
        mem_pend = 1'b0; mem_a = '0; mem_dbg_unused = 1'b0;
        fo = 1'b0; foa = '0; dq = 1'b0; dqa = '0; dwait = 0; nda = 0; nfr = 0;
        for (int c = 0; c < 3000; c++) rand_cycle(1'b1);
        for (int c = 0; c < 400 && (dq || fo); c++) rand_cycle(1'b0);
        chk("drain_debug", dq, 1'b0);
        chk("drain_fetch", fo, 1'b0);
        chk("rand_debug_seen", (nda > 10), 1'b1);
        chk("rand_fetch_seen", (nfr > 100), 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
